timer_arbiter: RTL and testbench
================================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter TIMER_W, default 32, width of delay values.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  per-requester delay request; level, held until matching done.
REQ-006 req_delay  input  NUM_REQ x TIMER_W  per-requester delay in cycles; valid while req high.
REQ-007 done  output  NUM_REQ  one-cycle pulse to the requester whose delay expired.
REQ-008 busy  output  1  high while any requester owns the timer.
REQ-009 active_id  output  clog2(NUM_REQ)  index of the current owner; valid while busy.
REQ-010 timer_set_val  output  TIMER_W  load value to the shared digital timer.
REQ-011 set_timer  output  1  one-cycle load strobe to the shared digital timer.
REQ-012 timer_is_high  input  1  expiry flag from the shared digital timer.

Function
REQ-013 FSM states IDLE, LOAD, WAIT, DONE; exactly one state active.
REQ-014 IDLE: if any req bit is high, select the owner round-robin, starting from the index after the last owner, and go to LOAD; otherwise stay.
REQ-015 LOAD (1 cycle): latch active_id, drive set_timer=1 and timer_set_val=req_delay[active_id], go to WAIT.
REQ-016 WAIT: ignore timer_is_high in the LOAD cycle; from the first WAIT cycle on, timer_is_high=1 moves the FSM to DONE.
REQ-017 Latency: for delay D, done pulses exactly D+2 cycles after the LOAD cycle (LOAD, D+1 WAIT cycles, DONE); D=0 gives done 2 cycles after LOAD.
REQ-018 DONE (1 cycle): pulse done[active_id]=1, update the round-robin pointer to active_id, go to IDLE.
REQ-019 Back-to-back: a requester may re-raise req in the cycle after done; it is serviced only after every other pending requester (fairness).
REQ-020 A req bit that drops before being granted is discarded with no done; after grant, req deassertion is ignored until DONE.
REQ-021 req_delay is sampled only in LOAD; later changes have no effect on the running delay.
REQ-022 Delay 2^TIMER_W-1 SHALL be handled with no internal overflow; the arbiter itself counts nothing.
REQ-023 busy=1 in LOAD, WAIT and DONE; 0 in IDLE.
REQ-024 set_timer is never high outside LOAD; done is one-hot or zero.

Reset
REQ-025 On rst=0, immediately: state=IDLE, done=0, set_timer=0, timer_set_val=0, busy=0, active_id=0, rr pointer = NUM_REQ-1 (so index 0 wins first).
REQ-026 Reset mid-delay abandons the owner with no done; the first arbitration after reset release starts at index 0.

Configuration
REQ-027 Macro TIMER_ARB_CANCEL_EN adds input cancel[NUM_REQ].
REQ-028 With it defined: cancel[active_id]=1 in WAIT moves the FSM to IDLE next cycle with no done pulse and updates the rr pointer; if cancel and timer_is_high are high in the same cycle, expiry wins and done pulses; cancel for a non-owner is ignored.
REQ-029 Without it: no cancel port; every grant ends in done.

Structure
REQ-030 Package timer_arb_pkg holds the FSM state enum (IDLE, LOAD, WAIT, DONE) and the default TIMER_W/NUM_REQ constants.
REQ-031 The round-robin selector is a sub-module rr_select (inputs: req vector and last-owner pointer; outputs: grant index and valid); it is purely combinational, and the pointer register lives in timer_arbiter.
REQ-032 The bench connects timer_arbiter to the existing digitalTimer model.

Verification
REQ-033 Single request: req[0]=1, delay 5 -> set_timer with value 5 one cycle after req; done[0] 7 cycles after LOAD; busy low the cycle after.
REQ-034 Zero delay: req[2]=1, delay 0 -> done[2] exactly 2 cycles after LOAD.
REQ-035 Fairness: req=4'b1111, delays 3,1,4,2 held continuously -> done order 0,1,2,3,0; no requester serviced twice before the others.
REQ-036 Reset mid-WAIT: delay 100 granted, rst low at cycle 10 of WAIT -> all outputs zero immediately, no done ever; the next grant goes to index 0.
REQ-037 Drop/late change: req[1] pulsed for 1 cycle while busy -> never serviced; req_delay[0] changed from 8 to 2 during WAIT -> done still at 8+2 cycles.
REQ-038 With TIMER_ARB_CANCEL_EN: cancel[0] in WAIT cycle 3 of delay 10 -> IDLE next cycle with no done[0]; pending req[1] is granted next; cancel coincident with timer_is_high -> done pulses.

Source files
------------

// File: rtl/timer_arb_pkg.sv
// rtl/timer_arb_pkg.sv - shared types and default sizes for the timer arbiter
package timer_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMER_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin pick starting after the last owner
module rr_select #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    grant,
  output logic               valid
);

  logic [ID_W-1:0] idx;

  // Walk from farthest to nearest so the index right after 'last' overrides the rest
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last) + k) % NUM_REQ);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin owner arbitration for one shared delay timer (optional cancel input: TIMER_ARB_CANCEL_EN)
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int TIMER_W = DEF_TIMER_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0][TIMER_W-1:0]  req_delay,
`ifdef TIMER_ARB_CANCEL_EN
  input  logic [NUM_REQ-1:0]               cancel,
`endif
  output logic [NUM_REQ-1:0]               done,
  output logic                             busy,
  output logic [ID_W-1:0]                  active_id,
  output logic [TIMER_W-1:0]               timer_set_val,
  output logic                             set_timer,
  input  logic                             timer_is_high
);

  arb_state_e      state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_valid;
  logic            cancel_exit;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .req   (req),
    .last  (rr_ptr),
    .grant (gnt_id),
    .valid (gnt_valid)
  );

  // Expiry has priority: a cancel only ends the grant while the timer is still low
`ifdef TIMER_ARB_CANCEL_EN
  assign cancel_exit = (state == WAIT) && !timer_is_high && cancel[active_id];
`else
  assign cancel_exit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Owner latch on grant; pointer advances only when a grant finishes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_id <= '0;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
    end else begin
      if (state == IDLE && gnt_valid) active_id <= gnt_id;
      if (state == DONE || cancel_exit) rr_ptr <= active_id;
    end
  end

  // Next-state logic; timer_is_high is only looked at in WAIT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (gnt_valid) state_nxt = LOAD;
      LOAD: state_nxt = WAIT;
      WAIT: begin
        if (timer_is_high)    state_nxt = DONE;
        else if (cancel_exit) state_nxt = IDLE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state and the latched owner
  always_comb begin
    busy          = (state != IDLE);
    set_timer     = (state == LOAD);
    timer_set_val = '0;
    done          = '0;
    if (state == LOAD) timer_set_val = req_delay[active_id];
    if (state == DONE) done[active_id] = 1'b1;
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - self-checking bench for timer_arbiter with a shared digital timer model
module tb_timer_arbiter;

  localparam int N  = 4;
  localparam int TW = 32;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N-1:0]         req = '0;
  logic [N-1:0][TW-1:0] req_delay = '0;
`ifdef TIMER_ARB_CANCEL_EN
  logic [N-1:0]         cancel = '0;
`endif
  logic [N-1:0]         done;
  logic                 busy;
  logic [IW-1:0]        active_id;
  logic [TW-1:0]        timer_set_val;
  logic                 set_timer;
  logic                 timer_is_high;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_done  = 0;

  always #5 clk = ~clk;

  timer_arbiter #(.NUM_REQ(N), .TIMER_W(TW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_delay     (req_delay),
`ifdef TIMER_ARB_CANCEL_EN
    .cancel        (cancel),
`endif
    .done          (done),
    .busy          (busy),
    .active_id     (active_id),
    .timer_set_val (timer_set_val),
    .set_timer     (set_timer),
    .timer_is_high (timer_is_high)
  );

  // digital timer: loads on set_timer, counts down, flag high once it reaches zero
  logic [TW-1:0] tmr_cnt = '0;
  logic          tmr_arm = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_cnt <= '0;
      tmr_arm <= 1'b0;
    end else if (set_timer) begin
      tmr_cnt <= timer_set_val;
      tmr_arm <= 1'b1;
    end else if (tmr_arm && tmr_cnt != 0) begin
      tmr_cnt <= tmr_cnt - 1;
    end
  end
  assign timer_is_high = tmr_arm && (tmr_cnt == 0);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: owner plus cycles elapsed since its load cycle
  bit     m_owned = 1'b0;
  int     m_owner = 0;
  int     m_last  = N - 1;
  longint m_t     = 0;
  longint m_d     = 0;
  int     pick;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owned <= 1'b0;
      m_owner <= 0;
      m_t     <= 0;
      m_d     <= 0;
      m_last  <= N - 1;
    end else if (!m_owned) begin
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && req[IW'((m_last + k) % N)]) pick = (m_last + k) % N;
      if (pick >= 0) begin
        m_owned <= 1'b1;
        m_owner <= pick;
        m_t     <= 0;
      end
    end else if (m_t == 0) begin
      m_d <= longint'(req_delay[IW'(m_owner)]);
      m_t <= 1;
    end else if (m_t == m_d + 2) begin
      m_owned <= 1'b0;
      m_last  <= m_owner;
`ifdef TIMER_ARB_CANCEL_EN
    end else if (cancel[IW'(m_owner)] && m_t <= m_d) begin
      m_owned <= 1'b0;
      m_last  <= m_owner;
`endif
    end else begin
      m_t <= m_t + 1;
    end
  end

  // Cycle-by-cycle comparison against the model
  logic          e_set;
  logic [TW-1:0] e_val;
  logic [N-1:0]  e_done;
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_set_timer", set_timer, 0);
      chk("rst_timer_set_val", timer_set_val, 0);
      chk("rst_active_id", active_id, 0);
    end else begin
      e_set  = m_owned && (m_t == 0);
      e_val  = e_set ? req_delay[IW'(m_owner)] : '0;
      e_done = '0;
      if (m_owned && m_t >= 1 && m_t == m_d + 2) e_done[IW'(m_owner)] = 1'b1;
      chk("busy", busy, m_owned);
      chk("set_timer", set_timer, e_set);
      chk("timer_set_val", timer_set_val, e_val);
      chk("done", done, e_done);
      if (m_owned) chk("active_id", active_id, m_owner);
      if (done != 0) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    req = '0;
`ifdef TIMER_ARB_CANCEL_EN
    cancel = '0;
`endif
    repeat (3) tick();
    rst = 1'b1;
  endtask

  task automatic wait_load(output int lc, output logic [TW-1:0] lv);
    bit ok = 1'b0;
    lc = -1;
    lv = '0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (set_timer) begin
        ok = 1'b1;
        lc = cyc;
        lv = timer_set_val;
      end
    end
    chk("load_seen", ok, 1);
  endtask

  task automatic wait_done(output int idx, output int dc);
    bit ok = 1'b0;
    idx = -1;
    dc  = -1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (done != 0) begin
        ok = 1'b1;
        dc = cyc;
        for (int b = 0; b < N; b++) if (done[IW'(b)]) idx = b;
      end
    end
    chk("done_seen", ok, 1);
  endtask

  int            lc, dc, idx, rc, nd0;
  logic [TW-1:0] lv;
  int            dly3[4] = '{3, 1, 4, 2};
  int            ord3[5] = '{0, 1, 2, 3, 0};

  initial begin
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // single request, delay 5
    req[0] = 1'b1; req_delay[0] = 5; rc = cyc;
    wait_load(lc, lv);
    chk("t1_load_cycle", lc, rc + 1);
    chk("t1_load_val", lv, 5);
    wait_done(idx, dc);
    chk("t1_done_idx", idx, 0);
    chk("t1_done_latency", dc - lc, 7);
    tick(); req[0] = 1'b0;
    @(negedge clk);
    chk("t1_busy_after", busy, 0);

    // zero delay
    tick(); req[2] = 1'b1; req_delay[2] = 0;
    wait_load(lc, lv);
    wait_done(idx, dc);
    chk("t2_done_idx", idx, 2);
    chk("t2_done_latency", dc - lc, 2);
    tick(); req = '0;

    // fairness with all four requesting continuously
    do_reset();
    for (int i = 0; i < N; i++) req_delay[i] = dly3[i];
    req = '1;
    for (int j = 0; j < 5; j++) begin
      wait_load(lc, lv);
      wait_done(idx, dc);
      chk("t3_order", idx, ord3[j]);
      chk("t3_latency", dc - lc, dly3[ord3[j]] + 2);
    end
    tick(); req = '0;

    // reset in the middle of a long wait
    do_reset();
    req[2] = 1'b1; req_delay[2] = 100;
    wait_load(lc, lv);
    repeat (11) tick();
    nd0 = n_done;
    rst = 1'b0; req = '0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_set_timer", set_timer, 0);
    chk("t4_timer_set_val", timer_set_val, 0);
    chk("t4_active_id", active_id, 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (110) tick();
    chk("t4_no_done", n_done, nd0);
    req[3] = 1'b1; req[0] = 1'b1; req_delay[3] = 1; req_delay[0] = 1;
    wait_done(idx, dc);
    chk("t4_first_after_reset", idx, 0);
    tick(); req[0] = 1'b0;
    wait_done(idx, dc);
    chk("t4_second_after_reset", idx, 3);
    tick(); req = '0;

    // dropped request and late delay change
    tick(); req[0] = 1'b1; req_delay[0] = 8;
    wait_load(lc, lv);
    tick(); tick();
    req[1] = 1'b1; req_delay[0] = 2;
    tick(); req[1] = 1'b0;
    nd0 = n_done;
    wait_done(idx, dc);
    chk("t5_done_idx", idx, 0);
    chk("t5_done_latency", dc - lc, 10);
    tick(); req = '0;
    repeat (20) tick();
    chk("t5_single_done", n_done, nd0 + 1);

    // all-ones delay loads unchanged
    req[1] = 1'b1; req_delay[1] = '1;
    wait_load(lc, lv);
    chk("t6_max_val", lv, 64'hFFFF_FFFF);
    repeat (5) tick();
    chk("t6_busy", busy, 1);
    do_reset();

`ifdef TIMER_ARB_CANCEL_EN
    // cancel during WAIT, then cancel coincident with expiry
    req[0] = 1'b1; req_delay[0] = 10;
    req[1] = 1'b1; req_delay[1] = 2;
    wait_load(lc, lv);
    repeat (3) tick();
    cancel[0] = 1'b1; req[0] = 1'b0;
    tick(); cancel = '0;
    @(negedge clk);
    chk("t7_idle_after_cancel", busy, 0);
    chk("t7_no_done_after_cancel", done, 0);
    wait_done(idx, dc);
    chk("t7_next_owner", idx, 1);
    tick(); req = '0;
    req[2] = 1'b1; req_delay[2] = 4;
    wait_load(lc, lv);
    repeat (5) tick();
    cancel[2] = 1'b1;
    wait_done(idx, dc);
    chk("t7_expiry_wins_idx", idx, 2);
    chk("t7_expiry_wins_latency", dc - lc, 6);
    tick(); cancel = '0; req = '0;
`endif

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (rst == 1'b0) rst = 1'b1;
      else if ($urandom_range(0, 699) == 0) rst = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
          else if ($urandom_range(0, 7) == 0) req_delay[i] = $urandom_range(0, 6);
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_delay[i] = $urandom_range(0, 6);
        end
      end
`ifdef TIMER_ARB_CANCEL_EN
      cancel = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
`endif
    end
    tick(); req = '0; rst = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
